mips_multi_control: RTL and testbench

MIPS_MULTI_CONTROL -- requirements
Module: mips_multi_control

---
 rtl/mips_multi_control_if.sv | 60 ++++++
 rtl/mips_multi_control.sv | 194 +++++++++++++++++++
 tb/tb_mips_multi_control.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_multi_control_if.sv
// Bundle of signals between the multi-cycle MIPS controller and its datapath.
// Macro: ILLEGAL_OPCODE_TRAP_EN adds the Illegal_o output.
//   Opcode_i  [5:0]            instruction bits [31:26] from the IR
//   Zero_i                     ALU zero flag
//   IorD_o .. PCWriteCond_o    1-bit datapath controls
//   ALUSrcB_o/ALUOp_o/PCSrc_o  2-bit datapath controls
//   PCEn_o                     PC load enable
//   State_o   [3:0]            current FSM state (debug)
//   Retired_o [DATA_WIDTH-1:0] retired-instruction count
//   Illegal_o                  high while trapped on an illegal opcode (macro only)
interface mips_multi_control_if #(
  parameter int DATA_WIDTH = 32
);
  logic [5:0]            Opcode_i;
  logic                  Zero_i;
  logic                  IorD_o;
  logic                  MemWrite_o;
  logic                  IRWrite_o;
  logic                  RegDst_o;
  logic                  MemtoReg_o;
  logic                  RegWrite_o;
  logic                  ALUSrcA_o;
  logic                  PCWrite_o;
  logic                  PCWriteCond_o;
  logic [1:0]            ALUSrcB_o;
  logic [1:0]            ALUOp_o;
  logic [1:0]            PCSrc_o;
  logic                  PCEn_o;
  logic [3:0]            State_o;
  logic [DATA_WIDTH-1:0] Retired_o;
`ifdef ILLEGAL_OPCODE_TRAP_EN
  logic                  Illegal_o;

  modport master (
    input  Opcode_i, Zero_i,
    output IorD_o, MemWrite_o, IRWrite_o, RegDst_o, MemtoReg_o, RegWrite_o,
           ALUSrcA_o, PCWrite_o, PCWriteCond_o, ALUSrcB_o, ALUOp_o, PCSrc_o,
           PCEn_o, State_o, Retired_o, Illegal_o
  );
  modport slave (
    output Opcode_i, Zero_i,
    input  IorD_o, MemWrite_o, IRWrite_o, RegDst_o, MemtoReg_o, RegWrite_o,
           ALUSrcA_o, PCWrite_o, PCWriteCond_o, ALUSrcB_o, ALUOp_o, PCSrc_o,
           PCEn_o, State_o, Retired_o, Illegal_o
  );
`else
  modport master (
    input  Opcode_i, Zero_i,
    output IorD_o, MemWrite_o, IRWrite_o, RegDst_o, MemtoReg_o, RegWrite_o,
           ALUSrcA_o, PCWrite_o, PCWriteCond_o, ALUSrcB_o, ALUOp_o, PCSrc_o,
           PCEn_o, State_o, Retired_o
  );
  modport slave (
    output Opcode_i, Zero_i,
    input  IorD_o, MemWrite_o, IRWrite_o, RegDst_o, MemtoReg_o, RegWrite_o,
           ALUSrcA_o, PCWrite_o, PCWriteCond_o, ALUSrcB_o, ALUOp_o, PCSrc_o,
           PCEn_o, State_o, Retired_o
  );
`endif
endinterface

// File: rtl/mips_multi_control.sv
// Moore control FSM for a multi-cycle MIPS datapath (lw, sw, R-type, beq,
// addi, j). Control outputs are registered copies of the decode of the next
// state, so they always reflect the state register; only PCEn_o mixes in the
// live Zero_i flag.
// Macro: ILLEGAL_OPCODE_TRAP_EN -- illegal opcodes lock the FSM in TRAP
// (Illegal_o=1) until reset; without it they retire as a NOP.
// Ports:
//   clk    single clock, posedge
//   reset  synchronous active-high reset
//   ctrl   mips_multi_control_if.master (opcode/zero in, controls/debug out)
module mips_multi_control #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  mips_multi_control_if.master  ctrl
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic       pcwrite;
    logic       pcwritecond;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  function automatic ctrl_t decode_state(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.irwrite = 1'b1;
        c.alusrcb = 2'b01;
        c.pcwrite = 1'b1;
      end
      S_DECODE: c.alusrcb = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_MEMRD: c.iord = 1'b1;
      S_MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      S_MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      S_EXEC: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b10;
      end
      S_ALUWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      S_BRANCH: begin
        c.alusrca     = 1'b1;
        c.aluop       = 2'b01;
        c.pcsrc       = 2'b01;
        c.pcwritecond = 1'b1;
      end
      S_ADDIWB: c.regwrite = 1'b1;
      S_JUMP: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t                r_state;
  ctrl_t                 r_ctrl;
  logic [DATA_WIDTH-1:0] r_retired;
  state_t                w_next;
  logic                  w_retire;
  logic                  w_pcwrite;
  logic                  w_pcwritecond;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: w_next = S_DECODE;
      S_DECODE: begin
        case (ctrl.Opcode_i)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
`ifdef ILLEGAL_OPCODE_TRAP_EN
          default:      w_next = S_TRAP;
`else
          default:      w_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: w_next = (ctrl.Opcode_i == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = S_MEMWB;
      S_EXEC:   w_next = S_ALUWB;
      S_ADDIEX: w_next = S_ADDIWB;
      S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: w_next = S_FETCH;
`ifdef ILLEGAL_OPCODE_TRAP_EN
      S_TRAP:   w_next = S_TRAP;
`endif
      default:  w_next = S_FETCH;
    endcase
    // Every completed instruction (including an illegal-opcode NOP) passes
    // back through FETCH; a stray TRAP recovery is not a completion.
    w_retire = (w_next == S_FETCH) && (r_state != S_TRAP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_ctrl    <= decode_state(S_FETCH);
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= decode_state(w_next);
      if (w_retire) begin
        r_retired <= r_retired + 1'b1;
      end
    end
  end

`ifdef ILLEGAL_OPCODE_TRAP_EN
  logic r_illegal;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= (w_next == S_TRAP);
    end
  end

  assign ctrl.Illegal_o = r_illegal;
`endif

  // Write/enable strobes are masked by the live reset so nothing is written
  // in a cycle where reset is asserted, whatever state the FSM is in.
  assign w_pcwrite          = r_ctrl.pcwrite & ~reset;
  assign w_pcwritecond      = r_ctrl.pcwritecond & ~reset;

  assign ctrl.IorD_o        = r_ctrl.iord;
  assign ctrl.MemWrite_o    = r_ctrl.memwrite & ~reset;
  assign ctrl.IRWrite_o     = r_ctrl.irwrite & ~reset;
  assign ctrl.RegDst_o      = r_ctrl.regdst;
  assign ctrl.MemtoReg_o    = r_ctrl.memtoreg;
  assign ctrl.RegWrite_o    = r_ctrl.regwrite & ~reset;
  assign ctrl.ALUSrcA_o     = r_ctrl.alusrca;
  assign ctrl.PCWrite_o     = w_pcwrite;
  assign ctrl.PCWriteCond_o = w_pcwritecond;
  assign ctrl.ALUSrcB_o     = r_ctrl.alusrcb;
  assign ctrl.ALUOp_o       = r_ctrl.aluop;
  assign ctrl.PCSrc_o       = r_ctrl.pcsrc;
  assign ctrl.PCEn_o        = w_pcwrite | (w_pcwritecond & ctrl.Zero_i);
  assign ctrl.State_o       = r_state;
  assign ctrl.Retired_o     = r_retired;

endmodule

// File: tb/tb_mips_multi_control.sv
// Self-checking bench for mips_multi_control. A narrow retired counter is
// used so the wrap-around is reachable with a short run of jumps.
// Honours ILLEGAL_OPCODE_TRAP_EN the same way as the design.
module tb_mips_multi_control;

  localparam int W = 4;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mips_multi_control_if #(.DATA_WIDTH(W)) ctrl_if ();

  mips_multi_control #(.DATA_WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (ctrl_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Expected per-cycle record.
  // ctl bit order: IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,
  //                PCWrite,PCWriteCond,ALUSrcB[1:0],ALUOp[1:0],PCSrc[1:0]
  typedef struct {
    logic [3:0]  state;
    logic [14:0] ctl;
    logic        pcen;
    logic [W-1:0] ret;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] exp_ret;

  function automatic logic [14:0] ref_ctl(input logic [3:0] s);
    case (s)
      4'd0:    return 15'b001_000_010_01_00_00;
      4'd1:    return 15'b000_000_000_11_00_00;
      4'd2:    return 15'b000_000_100_10_00_00;
      4'd3:    return 15'b100_000_000_00_00_00;
      4'd4:    return 15'b000_011_000_00_00_00;
      4'd5:    return 15'b110_000_000_00_00_00;
      4'd6:    return 15'b000_000_100_00_10_00;
      4'd7:    return 15'b000_101_000_00_00_00;
      4'd8:    return 15'b000_000_101_00_01_01;
      4'd9:    return 15'b000_000_100_10_00_00;
      4'd10:   return 15'b000_001_000_00_00_00;
      4'd11:   return 15'b000_000_010_00_00_10;
      default: return 15'b0;
    endcase
  endfunction

  function automatic int unsigned seq_len(input logic [5:0] op);
    case (op)
      6'h23:                return 5;
      6'h2B, 6'h00, 6'h08:  return 4;
      6'h04, 6'h02:         return 3;
      default:              return 2;
    endcase
  endfunction

  function automatic logic [3:0] seq_state(input logic [5:0] op, input int unsigned i);
    if (i == 0) return 4'd0;
    if (i == 1) return 4'd1;
    case (op)
      6'h23:   return (i == 2) ? 4'd2 : (i == 3) ? 4'd3 : 4'd4;
      6'h2B:   return (i == 2) ? 4'd2 : 4'd5;
      6'h00:   return (i == 2) ? 4'd6 : 4'd7;
      6'h08:   return (i == 2) ? 4'd9 : 4'd10;
      6'h04:   return 4'd8;
      6'h02:   return 4'd11;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [14:0] obs_ctl();
    return {ctrl_if.IorD_o, ctrl_if.MemWrite_o, ctrl_if.IRWrite_o,
            ctrl_if.RegDst_o, ctrl_if.MemtoReg_o, ctrl_if.RegWrite_o,
            ctrl_if.ALUSrcA_o, ctrl_if.PCWrite_o, ctrl_if.PCWriteCond_o,
            ctrl_if.ALUSrcB_o, ctrl_if.ALUOp_o, ctrl_if.PCSrc_o};
  endfunction

  // Called at a negedge with the DUT in FETCH. Pushes the expected trace,
  // then pops one record per cycle. The opcode is only meaningful in
  // DECODE/MEMADR; every other cycle sees random junk on it.
  task automatic run_instr(input string name, input logic [5:0] op, input logic z);
    exp_t e;
    for (int unsigned i = 0; i < seq_len(op); i++) begin
      e.state = seq_state(op, i);
      e.ctl   = ref_ctl(e.state);
      e.pcen  = e.ctl[7] | (e.ctl[6] & z);
      e.ret   = exp_ret;
      exp_q.push_back(e);
    end
    exp_ret = exp_ret + 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      ctrl_if.Zero_i   = z;
      ctrl_if.Opcode_i = (e.state == 4'd1 || e.state == 4'd2) ? op : 6'($urandom);
      #1;
      checks++;
      if (ctrl_if.State_o !== e.state) begin
        failures++;
        $display("FAIL %s state: got %0d want %0d", name, ctrl_if.State_o, e.state);
      end
      checks++;
      if (obs_ctl() !== e.ctl) begin
        failures++;
        $display("FAIL %s controls (state %0d): got %b want %b", name, e.state, obs_ctl(), e.ctl);
      end
      checks++;
      if (ctrl_if.PCEn_o !== e.pcen) begin
        failures++;
        $display("FAIL %s PCEn (state %0d): got %b want %b", name, e.state, ctrl_if.PCEn_o, e.pcen);
      end
      checks++;
      if (ctrl_if.Retired_o !== e.ret) begin
        failures++;
        $display("FAIL %s retired (state %0d): got %0d want %0d", name, e.state, ctrl_if.Retired_o, e.ret);
      end
`ifdef ILLEGAL_OPCODE_TRAP_EN
      checks++;
      if (ctrl_if.Illegal_o !== 1'b0) begin
        failures++;
        $display("FAIL %s Illegal_o: got %b want 0", name, ctrl_if.Illegal_o);
      end
`endif
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset   = 1'b0;
    exp_ret = '0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if ({ctrl_if.MemWrite_o, ctrl_if.RegWrite_o, ctrl_if.IRWrite_o,
         ctrl_if.PCWrite_o, ctrl_if.PCWriteCond_o, ctrl_if.PCEn_o} !== 6'b0) begin
      failures++;
      $display("FAIL reset_enables: got %b want 000000",
               {ctrl_if.MemWrite_o, ctrl_if.RegWrite_o, ctrl_if.IRWrite_o,
                ctrl_if.PCWrite_o, ctrl_if.PCWriteCond_o, ctrl_if.PCEn_o});
    end
    checks++;
    if (ctrl_if.State_o !== 4'd0) begin
      failures++;
      $display("FAIL reset_state: got %0d want 0", ctrl_if.State_o);
    end
    checks++;
    if (ctrl_if.Retired_o !== '0) begin
      failures++;
      $display("FAIL reset_retired: got %0d want 0", ctrl_if.Retired_o);
    end
    @(negedge clk);
    reset   = 1'b0;
    exp_ret = '0;
  endtask

  task automatic test_lw();
    run_instr("lw", 6'h23, 1'b0);
    checks++;
    if (ctrl_if.Retired_o !== W'(1)) begin
      failures++;
      $display("FAIL lw_retired: got %0d want 1", ctrl_if.Retired_o);
    end
  endtask

  task automatic test_types();
    run_instr("sw", 6'h2B, 1'b0);
    run_instr("rtype", 6'h00, 1'b1);
    run_instr("addi", 6'h08, 1'b0);
    run_instr("j", 6'h02, 1'b0);
  endtask

  task automatic test_beq();
    run_instr("beq_taken", 6'h04, 1'b1);
    run_instr("beq_not_taken", 6'h04, 1'b0);
  endtask

  task automatic test_illegal();
`ifdef ILLEGAL_OPCODE_TRAP_EN
    ctrl_if.Opcode_i = 6'h3F;
    ctrl_if.Zero_i   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      ctrl_if.Opcode_i = 6'($urandom);
      #1;
      checks++;
      if (ctrl_if.State_o !== 4'd12 || ctrl_if.Illegal_o !== 1'b1) begin
        failures++;
        $display("FAIL trap_state: got state %0d illegal %b want 12/1", ctrl_if.State_o, ctrl_if.Illegal_o);
      end
      checks++;
      if (obs_ctl() !== 15'b0 || ctrl_if.PCEn_o !== 1'b0) begin
        failures++;
        $display("FAIL trap_enables: got %b pcen %b want all 0", obs_ctl(), ctrl_if.PCEn_o);
      end
      checks++;
      if (ctrl_if.Retired_o !== exp_ret) begin
        failures++;
        $display("FAIL trap_retired: got %0d want %0d", ctrl_if.Retired_o, exp_ret);
      end
      @(posedge clk);
      @(negedge clk);
    end
    do_reset();
    #1;
    checks++;
    if (ctrl_if.State_o !== 4'd0 || ctrl_if.Illegal_o !== 1'b0) begin
      failures++;
      $display("FAIL trap_reset: got state %0d illegal %b want 0/0", ctrl_if.State_o, ctrl_if.Illegal_o);
    end
`else
    run_instr("illegal_nop", 6'h3F, 1'b0);
    checks++;
    if (ctrl_if.State_o !== 4'd0 || ctrl_if.Retired_o !== exp_ret) begin
      failures++;
      $display("FAIL illegal_retire: got state %0d retired %0d want 0/%0d",
               ctrl_if.State_o, ctrl_if.Retired_o, exp_ret);
    end
`endif
  endtask

  task automatic test_reset_mid();
    run_instr("pre_lw", 6'h23, 1'b0);
    ctrl_if.Opcode_i = 6'h2B;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    checks++;
    if (ctrl_if.State_o !== 4'd5 || ctrl_if.MemWrite_o !== 1'b1) begin
      failures++;
      $display("FAIL mid_memwr: got state %0d memwrite %b want 5/1", ctrl_if.State_o, ctrl_if.MemWrite_o);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (ctrl_if.MemWrite_o !== 1'b0 || ctrl_if.RegWrite_o !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_write: got memwrite %b regwrite %b want 0/0",
               ctrl_if.MemWrite_o, ctrl_if.RegWrite_o);
    end
    @(posedge clk);
    @(negedge clk);
    reset   = 1'b0;
    exp_ret = '0;
    #1;
    checks++;
    if (ctrl_if.State_o !== 4'd0 || ctrl_if.Retired_o !== '0) begin
      failures++;
      $display("FAIL mid_reset_after: got state %0d retired %0d want 0/0",
               ctrl_if.State_o, ctrl_if.Retired_o);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    repeat (15) run_instr("j_run", 6'h02, 1'b0);
    checks++;
    if (ctrl_if.Retired_o !== {W{1'b1}}) begin
      failures++;
      $display("FAIL wrap_allones: got %0d want %0d", ctrl_if.Retired_o, {W{1'b1}});
    end
    run_instr("j_wrap", 6'h02, 1'b0);
    checks++;
    if (ctrl_if.Retired_o !== '0) begin
      failures++;
      $display("FAIL wrap_zero: got %0d want 0", ctrl_if.Retired_o);
    end
    run_instr("j_after_wrap", 6'h02, 1'b1);
    run_instr("lw_after_wrap", 6'h23, 1'b0);
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    exp_ret          = '0;
    reset            = 1'b1;
    ctrl_if.Opcode_i = 6'h00;
    ctrl_if.Zero_i   = 1'b0;
    test_reset();
    test_lw();
    test_types();
    test_beq();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
